// File: rtl/atm_auth_requester.sv
// atm_auth_requester: terminal-side card/PIN collector and authentication requester.
// Optional verdict timeout enabled by defining AUTH_TIMEOUT_EN.
`timescale 1ns/1ps
module atm_auth_requester #(
  parameter int unsigned CARD_W      = 10,
  parameter int unsigned PIN_W       = 11,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned TRY_W       = 2,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              card_in,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic              auth_req,
  output logic [CARD_W-1:0] auth_card_no,
  output logic [PIN_W-1:0]  auth_pin,
  input  logic              auth_resp_valid,
  input  logic              auth_ok,
  output logic              session_ok,
  output logic              locked,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [TRY_W-1:0]  fail_cnt
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CARD_XW = CARD_W + 4;
  localparam int unsigned PIN_XW  = PIN_W + 4;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  localparam logic [1:0] ERR_AUTH_FAIL = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_EMPTY     = 2'd2;
`ifdef AUTH_TIMEOUT_EN
  localparam logic [1:0] ERR_TIMEOUT   = 2'd3;
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] tmr_q;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CARD, S_PIN, S_REQ, S_GRANTED, S_LOCKED
  } state_t;

  state_t            state_q;
  logic              armed_q;
  logic [CARD_W-1:0] card_q;
  logic [PIN_W-1:0]  pin_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;

  logic [CARD_XW-1:0] card_nxt_c;
  logic [PIN_XW-1:0]  pin_nxt_c;
  logic               acc_ovf_c;
  logic               key_digit_c, key_clear_c, key_enter_c, key_cancel_c;
  logic [TRY_W-1:0]   fail_inc_c;
  logic               lock_c;

  // Key decode, widened digit accumulation and failure-count arithmetic
  always_comb begin
    key_digit_c  = key_valid && (key_code <= 4'd9);
    key_clear_c  = key_valid && (key_code == KEY_CLEAR);
    key_enter_c  = key_valid && (key_code == KEY_ENTER);
    key_cancel_c = key_valid && (key_code == KEY_CANCEL);
    card_nxt_c   = CARD_XW'(card_q) * CARD_XW'(10) + CARD_XW'(key_code);
    pin_nxt_c    = PIN_XW'(pin_q) * PIN_XW'(10) + PIN_XW'(key_code);
    acc_ovf_c    = (state_q == S_CARD) ? (|card_nxt_c[CARD_XW-1:CARD_W])
                                       : (|pin_nxt_c[PIN_XW-1:PIN_W]);
    fail_inc_c   = (32'(fail_cnt) >= MAX_TRIES) ? fail_cnt : fail_cnt + TRY_W'(1);
    lock_c       = (32'(fail_cnt) + 32'd1) >= MAX_TRIES;
  end

  assign auth_card_no = card_q;
  assign auth_pin     = pin_q;

  // Session FSM with registered outputs and field accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      armed_q    <= 1'b1;
      card_q     <= '0;
      pin_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      auth_req   <= 1'b0;
      session_ok <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      fail_cnt   <= '0;
`ifdef AUTH_TIMEOUT_EN
      tmr_q      <= '0;
`endif
    end else begin
      err <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!card_in)     armed_q <= 1'b1;
          else if (armed_q) state_q <= S_CARD;
        end
        S_CARD, S_PIN: begin
          if (!card_in || key_cancel_c) begin
            state_q <= S_IDLE;
            armed_q <= ~card_in;
            card_q  <= '0;
            pin_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
          end else if (key_digit_c) begin
            if (acc_ovf_c) begin
              ovf_q <= 1'b1;
            end else begin
              if (state_q == S_CARD) card_q <= card_nxt_c[CARD_W-1:0];
              else                   pin_q  <= pin_nxt_c[PIN_W-1:0];
              if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (key_clear_c || (key_enter_c && ovf_q && (cnt_q != '0))) begin
            if (state_q == S_CARD) card_q <= '0;
            else                   pin_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            if (key_enter_c) begin
              err      <= 1'b1;
              err_code <= ERR_OVERFLOW;
            end
          end else if (key_enter_c) begin
            if (cnt_q == '0) begin
              err      <= 1'b1;
              err_code <= ERR_EMPTY;
            end else begin
              cnt_q <= '0;
              ovf_q <= 1'b0;
              if (state_q == S_CARD) begin
                state_q <= S_PIN;
              end else begin
                state_q  <= S_REQ;
                auth_req <= 1'b1;
`ifdef AUTH_TIMEOUT_EN
                tmr_q    <= '0;
`endif
              end
            end
          end
        end
        S_REQ: begin
          if (!card_in) begin
            state_q  <= S_IDLE;
            armed_q  <= 1'b1;
            auth_req <= 1'b0;
            card_q   <= '0;
            pin_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
          end else if (auth_resp_valid) begin
            auth_req <= 1'b0;
            if (auth_ok) begin
              state_q    <= S_GRANTED;
              session_ok <= 1'b1;
              fail_cnt   <= '0;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_AUTH_FAIL;
              fail_cnt <= fail_inc_c;
              if (lock_c) begin
                state_q <= S_LOCKED;
                locked  <= 1'b1;
              end else begin
                state_q <= S_PIN;
                pin_q   <= '0;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
              end
            end
          end
`ifdef AUTH_TIMEOUT_EN
          else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            auth_req <= 1'b0;
            state_q  <= S_PIN;
            pin_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
`endif
        end
        S_GRANTED: begin
          if (!card_in || key_cancel_c) begin
            state_q    <= S_IDLE;
            armed_q    <= ~card_in;
            session_ok <= 1'b0;
            card_q     <= '0;
            pin_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
          end
        end
        S_LOCKED: begin
          state_q <= S_LOCKED;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_auth_requester.sv
// Self-checking bench for atm_auth_requester: directed keypad/verdict sequences,
// a behavioural session model compared every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_atm_auth_requester;

  localparam int CARD_MAX = (1 << 10) - 1;
  localparam int PIN_MAX  = (1 << 11) - 1;
  localparam int TRIES    = 3;
  localparam int TO_CYC   = 8;

  logic        clk = 1'b0;
  logic        rst, card_in, key_valid, auth_resp_valid, auth_ok;
  logic [3:0]  key_code;
  logic        auth_req, session_ok, locked, err;
  logic [9:0]  auth_card_no;
  logic [10:0] auth_pin;
  logic [1:0]  err_code;
  logic [1:0]  fail_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  atm_auth_requester #(
    .CARD_W(10), .PIN_W(11), .MAX_TRIES(3), .TRY_W(2), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .card_in(card_in), .key_valid(key_valid), .key_code(key_code),
    .auth_req(auth_req), .auth_card_no(auth_card_no), .auth_pin(auth_pin),
    .auth_resp_valid(auth_resp_valid), .auth_ok(auth_ok), .session_ok(session_ok),
    .locked(locked), .err(err), .err_code(err_code), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: session phase, entered values, expected outputs
  localparam int P_IDLE = 0, P_CARD = 1, P_PIN = 2, P_REQ = 3, P_GRANT = 4, P_LOCK = 5;
  int ph, cval, pval, fcnt, req_age, m_code, m_fail;
  bit armed, fovf, m_req, m_sess, m_lock, m_err, started = 0;

  task automatic go_idle();
    ph = P_IDLE; cval = 0; pval = 0; fcnt = 0; fovf = 0;
    m_req = 0; m_sess = 0; armed = !card_in;
  endtask

  task automatic field_key();
    int lim, cur, nv;
    lim = (ph == P_CARD) ? CARD_MAX : PIN_MAX;
    cur = (ph == P_CARD) ? cval : pval;
    if (key_code <= 4'd9) begin
      nv = cur * 10 + int'(key_code);
      if (nv > lim) fovf = 1;
      else begin
        if (ph == P_CARD) cval = nv; else pval = nv;
        fcnt++;
      end
    end else if (key_code == 4'hB) begin
      if (ph == P_CARD) cval = 0; else pval = 0;
      fcnt = 0; fovf = 0;
    end else if (key_code == 4'hA) begin
      if (fcnt == 0) begin m_err = 1; m_code = 2; end
      else if (fovf) begin
        m_err = 1; m_code = 1;
        if (ph == P_CARD) cval = 0; else pval = 0;
        fcnt = 0; fovf = 0;
      end else begin
        fcnt = 0; fovf = 0;
        if (ph == P_CARD) ph = P_PIN;
        else begin ph = P_REQ; m_req = 1; req_age = 0; end
      end
    end else if (key_code == 4'hC) begin
      go_idle();
    end
  endtask

  task automatic model_step();
    m_err = 0;
    if (rst) begin
      ph = P_IDLE; armed = 1; cval = 0; pval = 0; fcnt = 0; fovf = 0;
      m_req = 0; m_sess = 0; m_lock = 0; m_code = 0; m_fail = 0;
      return;
    end
    case (ph)
      P_IDLE: if (!card_in) armed = 1; else if (armed) ph = P_CARD;
      P_CARD, P_PIN: if (!card_in) go_idle(); else if (key_valid) field_key();
      P_REQ: begin
        if (!card_in) go_idle();
        else if (auth_resp_valid) begin
          m_req = 0;
          if (auth_ok) begin ph = P_GRANT; m_sess = 1; m_fail = 0; end
          else begin
            m_err = 1; m_code = 0;
            if (m_fail < TRIES) m_fail++;
            if (m_fail == TRIES) begin ph = P_LOCK; m_lock = 1; end
            else begin ph = P_PIN; pval = 0; fcnt = 0; fovf = 0; end
          end
        end else begin
          req_age++;
`ifdef AUTH_TIMEOUT_EN
          if (req_age == TO_CYC) begin
            m_err = 1; m_code = 3; m_req = 0;
            ph = P_PIN; pval = 0; fcnt = 0; fovf = 0;
          end
`endif
        end
      end
      P_GRANT: if (!card_in || (key_valid && key_code == 4'hC)) go_idle();
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    model_step();
    started = 1;
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("auth_req", 32'(auth_req), 32'(m_req));
      check("session_ok", 32'(session_ok), 32'(m_sess));
      check("locked", 32'(locked), 32'(m_lock));
      check("err", 32'(err), 32'(m_err));
      check("err_code", 32'(err_code), 32'(m_code));
      check("fail_cnt", 32'(fail_cnt), 32'(m_fail));
      if (m_req) begin
        check("auth_card_no", 32'(auth_card_no), 32'(cval));
        check("auth_pin", 32'(auth_pin), 32'(pval));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1; key_code = k;
    tick(1);
    key_valid = 1'b0; key_code = 4'h0;
  endtask

  task automatic resp(input logic ok);
    auth_resp_valid = 1'b1; auth_ok = ok;
    tick(1);
    auth_resp_valid = 1'b0; auth_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1; card_in = 0; key_valid = 0; key_code = 0; auth_resp_valid = 0; auth_ok = 0;
    @(negedge clk); tick(2);
    rst = 0;
    check("rst auth_req", 32'(auth_req), 0);
    check("rst locked", 32'(locked), 0);
    check("rst fail_cnt", 32'(fail_cnt), 0);

    // Test 1: card 123, PIN 456, granted
    card_in = 1; tick(1);
    key(4'd1); key(4'd2); key(4'd3); key(4'hA);
    key(4'd4); key(4'd5); key(4'd6); key(4'hA);
    check("t1 auth_req", 32'(auth_req), 1);
    check("t1 card_no", 32'(auth_card_no), 123);
    check("t1 pin", 32'(auth_pin), 456);
    resp(1'b1);
    check("t1 session_ok", 32'(session_ok), 1);
    check("t1 auth_req drop", 32'(auth_req), 0);

    // Test 6a: reset in GRANTED
    rst = 1; tick(1); rst = 0;
    check("t6 granted rst session", 32'(session_ok), 0);

    // Test 2: three failed verdicts lock the terminal
    tick(1);
    key(4'd7); key(4'hA);
    key(4'd1); key(4'hA); resp(1'b0);
    check("t2 err1", 32'(err), 1);
    check("t2 fail1", 32'(fail_cnt), 1);
    key(4'd2); key(4'hA); resp(1'b0);
    check("t2 fail2", 32'(fail_cnt), 2);
    check("t2 not locked", 32'(locked), 0);
    key(4'd3); key(4'hA); resp(1'b0);
    check("t2 locked", 32'(locked), 1);
    check("t2 err_code", 32'(err_code), 0);
    card_in = 0; tick(2); card_in = 1; tick(1);
    key(4'd1); key(4'hA); key(4'hA); resp(1'b1); key(4'hC);
    check("t2 still locked", 32'(locked), 1);
    check("t2 fail sat", 32'(fail_cnt), 3);
    check("t2 no session", 32'(session_ok), 0);

    // Test 6b: reset in LOCKED
    rst = 1; tick(1); rst = 0;
    check("t6 lock rst locked", 32'(locked), 0);
    check("t6 lock rst fail", 32'(fail_cnt), 0);

    // Test 3: overflow, empty, clear
    tick(1);
    key(4'd1); key(4'd0); key(4'd2); key(4'd4); key(4'hA);
    check("t3 ovf err", 32'(err), 1);
    check("t3 ovf code", 32'(err_code), 1);
    key(4'hA);
    check("t3 empty code", 32'(err_code), 2);
    key(4'd9); key(4'd9); key(4'd9); key(4'hA);
    key(4'd5); key(4'hB); key(4'hA);
    check("t3 clear empty", 32'(err), 1);
    key(4'd8); key(4'hA);
    check("t3 req card", 32'(auth_card_no), 999);
    check("t3 req pin", 32'(auth_pin), 8);

    // Test 4: card removal beats a same-cycle verdict
    card_in = 0; auth_resp_valid = 1; auth_ok = 0; tick(1);
    auth_resp_valid = 0;
    check("t4 auth_req", 32'(auth_req), 0);
    check("t4 no err", 32'(err), 0);
    check("t4 fail kept", 32'(fail_cnt), 0);

    // Cancel requires re-insertion; keys D-F ignored; GRANTED cancel
    card_in = 1; tick(1);
    key(4'hC); tick(2); key(4'hA);
    check("cancel idle no err", 32'(err), 0);
    card_in = 0; tick(1); card_in = 1; tick(1);
    key(4'hA);
    check("rearm empty", 32'(err_code), 2);
    key(4'hD); key(4'hA);
    check("ignored key empty", 32'(err), 1);
    key(4'd5); key(4'hA); key(4'd6); key(4'hA); resp(1'b1);
    key(4'hC);
    check("grant cancel", 32'(session_ok), 0);
    card_in = 0; tick(1); card_in = 1; tick(1);

    // Test 5: verdict timeout
    key(4'd1); key(4'hA); key(4'd2); key(4'hA);
`ifdef AUTH_TIMEOUT_EN
    tick(TO_CYC - 1);
    check("t5 pre-expiry req", 32'(auth_req), 1);
    tick(1);
    check("t5 timeout err", 32'(err), 1);
    check("t5 timeout code", 32'(err_code), 3);
    check("t5 req drop", 32'(auth_req), 0);
    key(4'd3); key(4'hA);
    tick(TO_CYC - 1);
    resp(1'b1);
    check("t5 verdict wins", 32'(session_ok), 1);
    check("t5 no err", 32'(err), 0);
`else
    tick(20);
    check("t5 waits", 32'(auth_req), 1);
    resp(1'b1);
    check("t5 granted", 32'(session_ok), 1);
`endif
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
